// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-3 sequential demux.
package demux_pkg;

   localparam int unsigned NUM_CH        = 3;
   localparam int unsigned SEL_W         = 2;
   localparam int unsigned CNT_W         = 4;
   localparam int unsigned LIMIT_DEFAULT = 10;

   localparam logic [SEL_W-1:0] SEL_CH0     = 2'd0;
   localparam logic [SEL_W-1:0] SEL_CH1     = 2'd1;
   localparam logic [SEL_W-1:0] SEL_CH2     = 2'd2;
   localparam logic [SEL_W-1:0] SEL_ILLEGAL = 2'd3;

   // Round-robin successor of a channel select: 0 -> 1 -> 2 -> 0.
   function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
      return (s == SEL_CH2) ? SEL_CH0 : s + SEL_W'(1);
   endfunction

endpackage

// File: rtl/demux_dec.sv
// Combinational 2-to-3 one-hot decoder; code 3 raises the illegal flag.
module demux_dec
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0]  sel,
   output logic [NUM_CH-1:0] onehot,
   output logic              illegal
);

   // Decode select to one-hot channel enable.
   always_comb begin
      onehot  = '0;
      illegal = 1'b0;
      unique case (sel)
         SEL_CH0: onehot = 3'b001;
         SEL_CH1: onehot = 3'b010;
         SEL_CH2: onehot = 3'b100;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/demux1_3_seq.sv
// Registered 1-to-3 bit demux with transfer counter and sticky done.
// Build option: DEMUX_AUTOSEL_EN -- internal round-robin pointer replaces
// the sel port as the select source (err never asserts in that build).
module demux1_3_seq
   import demux_pkg::*;
#(
   parameter int unsigned LIMIT = LIMIT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             din,
   input  logic [SEL_W-1:0] sel,
   output logic             out0,
   output logic             out1,
   output logic             out2,
   output logic [2:0]       vld,
   output logic             err,
   output logic [SEL_W-1:0] cur_sel,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   logic [NUM_CH-1:0] out_q,   out_d;
   logic [NUM_CH-1:0] vld_q,   vld_d;
   logic              err_q,   err_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              done_q,  done_d;

   logic [SEL_W-1:0]  eff_sel;
   logic [NUM_CH-1:0] dec_onehot;
   logic              dec_illegal;
   logic              offered;
   logic              accept;

`ifdef DEMUX_AUTOSEL_EN
   logic [SEL_W-1:0]  ptr_q, ptr_d;

   // Internal pointer is the select source; the sel port is not used.
   assign eff_sel = ptr_q;
`else
   // External port is the select source.
   assign eff_sel = sel;
`endif

   assign cur_sel = eff_sel;

   demux_dec u_dec (
      .sel     (eff_sel),
      .onehot  (dec_onehot),
      .illegal (dec_illegal)
   );

   // Once done, offers are ignored entirely.
   assign offered = in_valid && !done_q;
   assign accept  = offered && !dec_illegal;

   // Next-state computation for channel data, strobes, counter and done.
   always_comb begin
      out_d   = out_q;
      vld_d   = '0;
      err_d   = 1'b0;
      count_d = count_q;
      done_d  = done_q;
      if (accept) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (dec_onehot[k]) out_d[k] = din;
         end
         vld_d   = dec_onehot;
         count_d = count_q + CNT_W'(1);
         if (count_d == CNT_W'(LIMIT)) done_d = 1'b1;
      end
`ifdef DEMUX_AUTOSEL_EN
      err_d = 1'b0;
`else
      err_d = offered && dec_illegal;
`endif
   end

`ifdef DEMUX_AUTOSEL_EN
   // Pointer advances only on accepted transfers.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = next_sel(ptr_q);
   end

   // Pointer register, restarts at channel 0 on reset.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= SEL_CH0;
      else     ptr_q <= ptr_d;
   end
`endif

   // State and output registers with synchronous reset priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         vld_q   <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         out_q   <= out_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign out0  = out_q[0];
   assign out1  = out_q[1];
   assign out2  = out_q[2];
   assign vld   = vld_q;
   assign err   = err_q;
   assign count = count_q;
   assign done  = done_q;

endmodule

// File: tb/tb_demux1_3_seq.sv
// Directed self-checking bench for demux1_3_seq (LIMIT = 10).
module tb_demux1_3_seq;
   import demux_pkg::*;

   logic       clk = 1'b0;
   logic       rst, in_valid, din;
   logic [1:0] sel;
   logic       out0, out1, out2;
   logic [2:0] vld;
   logic       err;
   logic [1:0] cur_sel;
   logic [3:0] count;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic       iv;
      logic       din;
      logic [1:0] sel;
      logic [2:0] e_out;
      logic [2:0] e_vld;
      logic       e_err;
      logic [3:0] e_cnt;
      logic       e_done;
   } vec_t;

   vec_t tv[10];

   demux1_3_seq #(.LIMIT(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .din      (din),
      .sel      (sel),
      .out0     (out0),
      .out1     (out1),
      .out2     (out2),
      .vld      (vld),
      .err      (err),
      .cur_sel  (cur_sel),
      .count    (count),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, sample 1 ns after rising edge.
   task automatic step(input logic r, input logic iv, input logic d, input logic [1:0] s);
      @(negedge clk);
      rst = r; in_valid = iv; din = d; sel = s;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [2:0] eo, input logic [2:0] ev,
                            input logic ee, input logic [3:0] ec, input logic ed);
      check($sformatf("%s.out", tag),   8'({out2, out1, out0}), 8'(eo));
      check($sformatf("%s.vld", tag),   8'(vld),   8'(ev));
      check($sformatf("%s.err", tag),   8'(err),   8'(ee));
      check($sformatf("%s.count", tag), 8'(count), 8'(ec));
      check($sformatf("%s.done", tag),  8'(done),  8'(ed));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; din = 1'b0; sel = 2'd0;

      //           rst   iv    din   sel    out     vld     err   cnt    done
      tv[0] = '{1'b1, 1'b1, 1'b1, 2'd1, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0};
      tv[1] = '{1'b0, 1'b1, 1'b1, 2'd1, 3'b010, 3'b010, 1'b0, 4'd1, 1'b0};
      tv[2] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'b010, 3'b000, 1'b0, 4'd1, 1'b0};
      tv[3] = '{1'b0, 1'b1, 1'b1, 2'd3, 3'b010, 3'b000, 1'b1, 4'd1, 1'b0};
      tv[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'b010, 3'b000, 1'b0, 4'd1, 1'b0};
      tv[5] = '{1'b0, 1'b1, 1'b1, 2'd0, 3'b011, 3'b001, 1'b0, 4'd2, 1'b0};
      tv[6] = '{1'b0, 1'b1, 1'b1, 2'd2, 3'b111, 3'b100, 1'b0, 4'd3, 1'b0};
      tv[7] = '{1'b0, 1'b1, 1'b0, 2'd1, 3'b101, 3'b010, 1'b0, 4'd4, 1'b0};
      tv[8] = '{1'b0, 1'b1, 1'b0, 2'd0, 3'b100, 3'b001, 1'b0, 4'd5, 1'b0};
      tv[9] = '{1'b1, 1'b1, 1'b1, 2'd2, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0};

      step(1'b1, 1'b0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 1'b0, 2'd0);

`ifndef DEMUX_AUTOSEL_EN
      // External-select vectors: reset priority, routing, illegal select, reset mid-run.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rst = tv[i].rst; in_valid = tv[i].iv; din = tv[i].din; sel = tv[i].sel;
         #1;
         check($sformatf("v%0d.cur_sel", i), 8'(cur_sel), 8'(tv[i].sel));
         @(posedge clk);
         #1;
         check_all($sformatf("v%0d", i), tv[i].e_out, tv[i].e_vld, tv[i].e_err,
                   tv[i].e_cnt, tv[i].e_done);
      end
`else
      // Autoselect: sel tied to 3, writes follow the 0,1,2,0 pointer.
      step(1'b0, 1'b1, 1'b1, 2'd3); check_all("a0", 3'b001, 3'b001, 1'b0, 4'd1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 2'd3); check_all("a1", 3'b001, 3'b010, 1'b0, 4'd2, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'd3); check_all("a2", 3'b101, 3'b100, 1'b0, 4'd3, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'd3); check_all("a3", 3'b101, 3'b001, 1'b0, 4'd4, 1'b0);
      step(1'b0, 1'b0, 1'b0, 2'd3); check_all("a4", 3'b101, 3'b000, 1'b0, 4'd4, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'd3); check_all("a5", 3'b111, 3'b010, 1'b0, 4'd5, 1'b0);
      // Reset with a simultaneous offer after 5 transfers; pointer back to 0.
      step(1'b1, 1'b1, 1'b1, 2'd3); check_all("a6", 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
      check("a6.cur_sel", 8'(cur_sel), 8'(SEL_CH0));
      step(1'b0, 1'b1, 1'b1, 2'd3); check_all("a7", 3'b001, 3'b001, 1'b0, 4'd1, 1'b0);
`endif

      // Saturation: 12 transfers cycling 0,1,2; last two use din=0 and must not land.
      step(1'b1, 1'b0, 1'b0, 2'd0);
      check_all("sat.rst", 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         logic [1:0] s;
         logic [2:0] eo, ev;
         s  = 2'(i % 3);
         step(1'b0, 1'b1, (i < 10) ? 1'b1 : 1'b0, s);
         eo = (i == 0) ? 3'b001 : (i == 1) ? 3'b011 : 3'b111;
         ev = (i < 10) ? 3'(1 << s) : 3'b000;
         check_all($sformatf("sat%0d", i), eo, ev, 1'b0,
                   (i < 10) ? 4'(i + 1) : 4'd10, (i >= 9) ? 1'b1 : 1'b0);
      end
      // Illegal select while done: no err.
      step(1'b0, 1'b1, 1'b0, 2'd3);
      check_all("sat.ill", 3'b111, 3'b000, 1'b0, 4'd10, 1'b1);

      // Reset after done restarts counting.
      step(1'b1, 1'b0, 1'b0, 2'd0);
      check_all("rst2", 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 2'd0);
      check_all("post", 3'b001, 3'b001, 1'b0, 4'd1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 2'd0);
      check_all("idle", 3'b001, 3'b000, 1'b0, 4'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux1_3_seq.md
DEMUX1_3_SEQ -- requirements
Module: demux1_3_seq

Interface
REQ-001 Parameter LIMIT, default 10, number of accepted transfers after which the block stops (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  din is offered this cycle.
REQ-005 din  input  1  data bit to be routed.
REQ-006 sel  input  2  external channel select: 0/1/2 valid, 3 illegal.
REQ-007 out0, out1, out2  output  1 each  registered hold value per channel.
REQ-008 vld  output  3  one-hot strobe; bit k high for one cycle when outk was just written.
REQ-009 err  output  1  one-cycle pulse on an offered transfer with illegal select.
REQ-010 cur_sel  output  2  effective select used for the current cycle.
REQ-011 count  output  4  number of accepted transfers, saturating at LIMIT.
REQ-012 done  output  1  sticky; high once count equals LIMIT.

Function
REQ-013 An accepted transfer is a rising edge with in_valid=1, done=0, rst=0 and effective select in 0..2.
REQ-014 On an accepted transfer: out[sel] <= din; vld <= one-hot(sel) next cycle; other outputs hold; count <= count+1.
REQ-015 Latency din -> outk and vld: exactly one clock.
REQ-016 vld SHALL be 3'b000 in any cycle following a non-accepted edge.
REQ-017 Offered transfer with effective select 3: no output written, count unchanged, err=1 for one cycle, vld=0.
REQ-018 done <= 1 on the edge where count becomes LIMIT; while done=1 all in_valid is ignored (no writes, no vld, no err, count holds).
REQ-019 in_valid=0: outputs hold, vld=0, err=0, count holds.
REQ-020 cur_sel is combinational from effective select (external sel or internal pointer per REQ-025/026).

Reset
REQ-021 rst=1 at a rising edge: out0..out2=0, vld=0, err=0, count=0, done=0, internal select pointer=0.
REQ-022 rst has priority over any simultaneous in_valid; the transfer in that cycle is discarded.
REQ-023 Reset mid-sequence or after done restarts the block fully; a new LIMIT transfers are accepted.

Configuration
REQ-024 Macro DEMUX_AUTOSEL_EN selects the select source.
REQ-025 Defined: internal 2-bit pointer drives effective select, sequence 0,1,2,0,... advancing only on accepted transfers; sel port ignored; err never asserts.
REQ-026 Undefined: sel port drives effective select; no internal pointer; err behaviour per REQ-017.

Structure
REQ-027 Shared package demux_pkg holds NUM_CH=3, SEL_CH0=2'd0, SEL_CH1=2'd1, SEL_CH2=2'd2, SEL_ILLEGAL=2'd3 and the default LIMIT.
REQ-028 One sub-module demux_dec: combinational 2-to-3 one-hot decoder with illegal flag, instantiated once.

Verification
REQ-029 Reset then sel=1, din=1, in_valid=1 one cycle -> next cycle out1=1, vld=3'b010, out0=out2=0, count=1.
REQ-030 Macro undefined, sel=3, in_valid=1 -> err=1 one cycle, vld=0, outputs unchanged, count unchanged.
REQ-031 LIMIT=10, 12 consecutive valid transfers sel cycling 0,1,2 -> done=1 after 10th, count=10, transfers 11-12 produce no vld and no output change.
REQ-032 Macro defined, sel tied to 3, din pattern 1,0,1,1 -> writes go to out0,out1,out2,out0; vld 001,010,100,001; err stays 0.
REQ-033 rst=1 asserted together with in_valid after 5 transfers -> next cycle all outputs 0, count=0, done=0, vld=0; pointer restarts at 0.
